// File: rtl/systolic_array_radix4.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_radix4
// Description : Output-stationary SIZE x SIZE systolic matrix multiplier.
//               Each PE has a radix-4 Booth multiplier and a 2W-bit accumulator.
//               Macro SYSTOLIC_SIGNED_EN selects two's-complement operands.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_array_radix4 #(
  parameter int SIZE       = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [SIZE*DATA_WIDTH-1:0]           A,
  input  logic [SIZE*DATA_WIDTH-1:0]           B,
  output logic                                 done,
  output logic [SIZE*SIZE*2*DATA_WIDTH-1:0]    C
);

  localparam int c_w     = DATA_WIDTH;
  localparam int c_pw    = 2 * DATA_WIDTH;
  localparam int c_cnt_w = $clog2(3 * SIZE) + 1;
  // Counter value seen just before the edge that must raise done.
  localparam logic [c_cnt_w-1:0] c_done_cnt = c_cnt_w'(3 * SIZE - 3);

  // Modified Booth: W+2 bit multiplier, W/2+1 digits in {-2..+2}, summed mod 2^(2W).
  function automatic logic [c_pw-1:0] booth_mul(input logic [c_w-1:0] a,
                                                input logic [c_w-1:0] b);
    logic [c_pw-1:0] a_ext;
    logic [c_pw-1:0] pp;
    logic [c_pw-1:0] sum;
    logic [c_w+2:0]  b_ext;
    logic [2:0]      trip;
    sum = '0;
`ifdef SYSTOLIC_SIGNED_EN
    a_ext = {{c_w{a[c_w-1]}}, a};
    b_ext = {{2{b[c_w-1]}}, b, 1'b0};
`else
    a_ext = {{c_w{1'b0}}, a};
    b_ext = {2'b00, b, 1'b0};
`endif
    for (int k = 0; k <= c_w / 2; k++) begin
      trip = b_ext[2*k +: 3];
      case (trip)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext << 1;
        3'b100:         pp = -(a_ext << 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      sum = sum + (pp << (2 * k));
    end
    return sum;
  endfunction

  logic [c_cnt_w-1:0]     r_cnt;
  logic                   r_done;
  logic [SIZE*SIZE*c_w-1:0] w_a_q;
  logic [SIZE*SIZE*c_w-1:0] w_b_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (!r_done) begin
      r_cnt  <= r_cnt + 1'b1;
      r_done <= (r_cnt == c_done_cnt);
    end
  end

  assign done = r_done;

  for (genvar i = 0; i < SIZE; i++) begin : g_row
    for (genvar j = 0; j < SIZE; j++) begin : g_col
      logic [c_w-1:0]  r_a;
      logic [c_w-1:0]  r_b;
      logic [c_pw-1:0] r_acc;
      logic [c_w-1:0]  w_a_in;
      logic [c_w-1:0]  w_b_in;
      logic [c_pw-1:0] w_prod;

      if (j == 0) begin : g_a_edge
        assign w_a_in = A[i*c_w +: c_w];
      end else begin : g_a_chain
        assign w_a_in = w_a_q[(i*SIZE+j-1)*c_w +: c_w];
      end

      if (i == 0) begin : g_b_edge
        assign w_b_in = B[j*c_w +: c_w];
      end else begin : g_b_chain
        assign w_b_in = w_b_q[((i-1)*SIZE+j)*c_w +: c_w];
      end

      assign w_prod = booth_mul(w_a_in, w_b_in);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_a   <= '0;
          r_b   <= '0;
          r_acc <= '0;
        end else if (!r_done) begin
          r_a   <= w_a_in;
          r_b   <= w_b_in;
          r_acc <= r_acc + w_prod;
        end
      end

      assign w_a_q[(i*SIZE+j)*c_w +: c_w]   = r_a;
      assign w_b_q[(i*SIZE+j)*c_w +: c_w]   = r_b;
      assign C[(i*SIZE+j)*c_pw +: c_pw]     = r_acc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_radix4.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_array_radix4
// Description : Directed self-checking bench for systolic_array_radix4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_array_radix4;

  localparam int SIZE      = 8;
  localparam int W         = 32;
  localparam int PW        = 64;
  localparam int LAST_EDGE = 3 * SIZE - 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [SIZE*W-1:0]       A = '0;
  logic [SIZE*W-1:0]       B = '0;
  logic                    done;
  logic [SIZE*SIZE*PW-1:0] C;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0]  ma    [SIZE][SIZE];
  logic [W-1:0]  mb    [SIZE][SIZE];
  logic [PW-1:0] exp_c [SIZE][SIZE];

  systolic_array_radix4 #(.SIZE(SIZE), .DATA_WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .done (done),
    .C    (C)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] c_at(input int i, input int j);
    return C[(i*SIZE+j)*PW +: PW];
  endfunction

  task automatic clear_mats();
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        ma[i][j] = '0;
        mb[i][j] = '0;
      end
  endtask

  // Reference matrix product, wrapped to 2W bits.
  task automatic compute_expected();
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        logic [PW-1:0] s;
        s = '0;
        for (int k = 0; k < SIZE; k++)
          s = s + PW'(ma[i][k]) * PW'(mb[k][j]);
        exp_c[i][j] = s;
      end
  endtask

  task automatic load_req021();
    int row0 [SIZE] = '{37, 60, 1, 5, 52, 23, 44, 50};
    int col0 [SIZE] = '{2, 47, 2, 5, 16, 48, 46, 53};
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) begin
        ma[i][k] = (i == 0) ? W'(row0[k]) : W'(i * 3 + k + 1);
        mb[i][k] = (k == 0) ? W'(col0[i]) : W'(i + 2 * k + 1);
      end
    compute_expected();
  endtask

  task automatic apply_reset();
    A   = '0;
    B   = '0;
    rst = 1'b0;
    #2;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Lane i carries ma[i][c-i]; lane j carries mb[c-j][j].
  task automatic drive_cycle(input int c);
    for (int i = 0; i < SIZE; i++) begin
      int k = c - i;
      A[i*W +: W] = (k >= 0 && k < SIZE) ? ma[i][k] : '0;
      B[i*W +: W] = (k >= 0 && k < SIZE) ? mb[k][i] : '0;
    end
  endtask

  task automatic feed_cycles(input int c0, input int c1);
    for (int c = c0; c < c1; c++) begin
      drive_cycle(c);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    A = '1;
    B = '1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got %0b expected 0", done);
    end
    checks++;
    if (C !== '0) begin
      failures++;
      $display("FAIL reset_c: got nonzero C expected all zero, C00=%0h", c_at(0, 0));
    end
  endtask

  task automatic test_matmul();
    clear_mats();
    load_req021();
    apply_reset();
    feed_cycles(0, LAST_EDGE - 1);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL matmul_done_early: got %0b expected 0 at edge %0d", done, LAST_EDGE - 1);
    end
    feed_cycles(LAST_EDGE - 1, LAST_EDGE);
    A = '0;
    B = '0;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL matmul_done_edge: got %0b expected 1 at edge %0d", done, LAST_EDGE);
    end
    checks++;
    if (c_at(0, 0) !== 64'd9531) begin
      failures++;
      $display("FAIL matmul_c00: got %0d expected 9531", c_at(0, 0));
    end
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        checks++;
        if (c_at(i, j) !== exp_c[i][j]) begin
          failures++;
          $display("FAIL matmul_c(%0d,%0d): got %0d expected %0d", i, j, c_at(i, j), exp_c[i][j]);
        end
      end
  endtask

  task automatic test_identity();
    clear_mats();
    for (int i = 0; i < SIZE; i++) begin
      ma[i][i] = 32'd1;
      for (int j = 0; j < SIZE; j++)
        mb[i][j] = W'(8 * i + j);
    end
    apply_reset();
    feed_cycles(0, LAST_EDGE);
    A = '0;
    B = '0;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL identity_done: got %0b expected 1", done);
    end
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        checks++;
        if (c_at(i, j) !== PW'(8 * i + j)) begin
          failures++;
          $display("FAIL identity_c(%0d,%0d): got %0d expected %0d", i, j, c_at(i, j), 8 * i + j);
        end
      end
  endtask

  task automatic test_wide_product();
    logic [PW-1:0] want;
    clear_mats();
`ifdef SYSTOLIC_SIGNED_EN
    ma[0][0] = 32'hFFFF_FFFF;
    mb[0][0] = 32'd5;
    want     = 64'hFFFF_FFFF_FFFF_FFFB;
`else
    ma[0][0] = 32'hFFFF_FFFF;
    mb[0][0] = 32'hFFFF_FFFF;
    want     = 64'hFFFF_FFFE_0000_0001;
`endif
    apply_reset();
    feed_cycles(0, LAST_EDGE);
    A = '0;
    B = '0;
    checks++;
    if (c_at(0, 0) !== want) begin
      failures++;
      $display("FAIL wide_c00: got %0h expected %0h", c_at(0, 0), want);
    end
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        if (i != 0 || j != 0) begin
          checks++;
          if (c_at(i, j) !== '0) begin
            failures++;
            $display("FAIL wide_c(%0d,%0d): got %0h expected 0", i, j, c_at(i, j));
          end
        end
  endtask

  task automatic test_reset_midrun();
    clear_mats();
    load_req021();
    apply_reset();
    feed_cycles(0, 10);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (C !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midrun_async_clear: got C00=%0h done=%0b expected 0 0", c_at(0, 0), done);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (C !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midrun_held_clear: got C00=%0h done=%0b expected 0 0", c_at(0, 0), done);
    end
    @(negedge clk);
    rst = 1'b1;
    feed_cycles(0, LAST_EDGE - 1);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL midrun_done_early: got %0b expected 0", done);
    end
    feed_cycles(LAST_EDGE - 1, LAST_EDGE);
    A = '0;
    B = '0;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL midrun_done_edge: got %0b expected 1", done);
    end
    checks++;
    if (c_at(0, 0) !== 64'd9531) begin
      failures++;
      $display("FAIL midrun_c00: got %0d expected 9531", c_at(0, 0));
    end
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        checks++;
        if (c_at(i, j) !== exp_c[i][j]) begin
          failures++;
          $display("FAIL midrun_c(%0d,%0d): got %0d expected %0d", i, j, c_at(i, j), exp_c[i][j]);
        end
      end
  endtask

  // Runs right after a completed REQ-021 run; exp_c still holds its result.
  task automatic test_freeze();
    for (int n = 0; n < 5; n++) begin
      for (int l = 0; l < SIZE; l++) begin
        A[l*W +: W] = W'($urandom) | 32'h1;
        B[l*W +: W] = W'($urandom) | 32'h1;
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1) begin
        failures++;
        $display("FAIL freeze_done[%0d]: got %0b expected 1", n, done);
      end
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++) begin
          checks++;
          if (c_at(i, j) !== exp_c[i][j]) begin
            failures++;
            $display("FAIL freeze_c(%0d,%0d)[%0d]: got %0d expected %0d", i, j, n, c_at(i, j), exp_c[i][j]);
          end
        end
    end
    A = '0;
    B = '0;
  endtask

  initial begin
    test_reset();
    test_matmul();
    test_identity();
    test_wide_product();
    test_reset_midrun();
    test_freeze();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
